// File: rtl/seven_segment_capture.sv
// Receive-side monitor for the multiplexed 4-digit seven-segment bus.
// Decodes each settled digit back to BCD and reassembles minutes/seconds frames.
module seven_segment_capture #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  select,
  input  logic [7:0]  sevensegment,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [6:0]  minutes,
  output logic [5:0]  seconds,
  output logic        frame_valid,
  output logic        err
);

  localparam int unsigned CW = $clog2(SETTLE + 1);

  logic [3:0]       s_sel;
  logic [6:0]       s_seg;
  logic [CW-1:0]    stab_cnt;
  logic [3:0][3:0]  stage;
  logic [3:0]       mask;

  logic             same_c;
  logic             strobe_c;
  logic             cap_c;
  logic             cap_err_c;
  logic [1:0]       k_c;
  logic             k_ok_c;
  logic [4:0]       dec_c;
  logic [3:0]       stage_blank_c;
  logic [6:0]       min_full_c;
  logic [6:0]       sec_full_c;

  // {valid, bcd}; blank decodes as a valid 4'hF
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = {1'b1, 4'd0};
      7'h79:   decode = {1'b1, 4'd1};
      7'h24:   decode = {1'b1, 4'd2};
      7'h30:   decode = {1'b1, 4'd3};
      7'h19:   decode = {1'b1, 4'd4};
      7'h12:   decode = {1'b1, 4'd5};
      7'h02:   decode = {1'b1, 4'd6};
      7'h78:   decode = {1'b1, 4'd7};
      7'h00:   decode = {1'b1, 4'd8};
      7'h10:   decode = {1'b1, 4'd9};
      7'h7F:   decode = {1'b1, 4'hF};
      default: decode = {1'b0, 4'hF};
    endcase
  endfunction

  function automatic logic [6:0] mul10(input logic [3:0] d);
    mul10 = {d, 3'b000} + {2'b00, d, 1'b0};
  endfunction

  // stab_cnt tracks how long the registered bus has held its current value
  assign same_c   = ({select, sevensegment[6:0]} == {s_sel, s_seg});
  assign strobe_c = (stab_cnt == CW'(SETTLE - 1));
  assign dec_c    = decode(s_seg);

  always_comb begin
    k_c       = 2'd0;
    k_ok_c    = 1'b0;
    cap_c     = 1'b0;
    cap_err_c = 1'b0;
    if (strobe_c) begin
      case (s_sel)
        4'b1110: begin k_c = 2'd0; k_ok_c = 1'b1; end
        4'b1101: begin k_c = 2'd1; k_ok_c = 1'b1; end
        4'b1011: begin k_c = 2'd2; k_ok_c = 1'b1; end
        4'b0111: begin k_c = 2'd3; k_ok_c = 1'b1; end
        4'b1111: ;
        default: cap_err_c = 1'b1;
      endcase
      if (k_ok_c) begin
        if (dec_c[4]) cap_c     = 1'b1;
        else          cap_err_c = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) stage_blank_c[i] = (stage[i] == 4'hF);
    min_full_c = mul10(stage[3]) + 7'(stage[2]);
    sec_full_c = mul10(stage[1]) + 7'(stage[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_sel       <= 4'hF;
      s_seg       <= 7'h7F;
      stab_cnt    <= '0;
      stage       <= {4{4'hF}};
      mask        <= 4'h0;
      digits      <= 16'hFFFF;
      blank       <= 4'hF;
      minutes     <= 7'd0;
      seconds     <= 6'd0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      s_sel       <= select;
      s_seg       <= sevensegment[6:0];
      frame_valid <= 1'b0;
      err         <= cap_err_c;

      if (!same_c)                        stab_cnt <= '0;
      else if (stab_cnt != CW'(SETTLE))   stab_cnt <= stab_cnt + CW'(1);

      // Publish a completed frame; blanked halves keep their previous value
      if (mask == 4'hF) begin
        digits      <= stage;
        blank       <= stage_blank_c;
        frame_valid <= 1'b1;
        mask        <= 4'h0;
        if (!stage_blank_c[3] && !stage_blank_c[2]) minutes <= min_full_c;
        if (!stage_blank_c[1] && !stage_blank_c[0]) begin
          if (sec_full_c > 7'd59) err <= 1'b1;
          else                    seconds <= sec_full_c[5:0];
        end
      end

      if (cap_c) begin
        stage[k_c] <= dec_c[3:0];
        mask[k_c]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: scans hand-built frames and
// checks decoded outputs and pulse counts against hand-computed values.
module tb_seven_segment_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  select;
  logic [7:0]  sevensegment;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [6:0]  minutes;
  logic [5:0]  seconds;
  logic        frame_valid;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int fv0, err0, both0;

  seven_segment_capture #(.SETTLE(4)) dut (
    .clk(clk), .reset(reset), .select(select), .sevensegment(sevensegment),
    .digits(digits), .blank(blank), .minutes(minutes), .seconds(seconds),
    .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (frame_valid)        fv_cnt++;
    if (err)                err_cnt++;
    if (frame_valid && err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] seg(input int v);
    case (v)
      0: seg = 8'hC0;  1: seg = 8'hF9;  2: seg = 8'hA4;  3: seg = 8'hB0;
      4: seg = 8'h99;  5: seg = 8'h92;  6: seg = 8'h82;  7: seg = 8'hF8;
      8: seg = 8'h80;  9: seg = 8'h90;  default: seg = 8'hFF;
    endcase
  endfunction

  task automatic dwell(input logic [3:0] sel, input logic [7:0] sg, input int n);
    select       = sel;
    sevensegment = sg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic digit(input int k, input int v, input int n);
    logic [3:0] one;
    one = 4'b0001 << k;
    dwell(~one, seg(v), n);
  endtask

  task automatic idle();
    dwell(4'hF, 8'hFF, 8);
  endtask

  task automatic mark();
    fv0 = fv_cnt; err0 = err_cnt; both0 = both_cnt;
  endtask

  initial begin
    reset = 1'b1; select = 4'hF; sevensegment = 8'hFF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_digits", 32'(digits), 32'hFFFF);
    check("rst_blank", 32'(blank), 32'hF);
    check("rst_min", 32'(minutes), 0);
    check("rst_sec", 32'(seconds), 0);
    check("rst_fv", 32'(frame_valid), 0);
    check("rst_err", 32'(err), 0);
    idle();

    // Normal scan 12:34, with frame_valid latency on the last digit
    mark();
    digit(0, 4, 8); digit(1, 3, 8); digit(2, 2, 8);
    dwell(4'b0111, seg(1), 5);
    check("t1_fv_early", 32'(frame_valid), 0);
    dwell(4'b0111, seg(1), 1);
    check("t1_fv_on", 32'(frame_valid), 1);
    dwell(4'b0111, seg(1), 2);
    idle();
    check("t1_digits", 32'(digits), 32'h1234);
    check("t1_min", 32'(minutes), 12);
    check("t1_sec", 32'(seconds), 34);
    check("t1_blank", 32'(blank), 0);
    check("t1_fvcnt", 32'(fv_cnt - fv0), 1);
    check("t1_errcnt", 32'(err_cnt - err0), 0);

    // Glitch shorter than SETTLE is dropped; long hold captures once
    mark();
    digit(0, 0, 3); idle();
    digit(1, 5, 8); digit(2, 4, 8); digit(3, 2, 8); idle();
    check("t2_glitch_nofv", 32'(fv_cnt - fv0), 0);
    digit(0, 0, 100); idle();
    check("t2_hold_fv", 32'(fv_cnt - fv0), 1);
    check("t2_digits", 32'(digits), 32'h2450);
    check("t2_min", 32'(minutes), 24);
    check("t2_sec", 32'(seconds), 50);
    check("t2_err", 32'(err_cnt - err0), 0);

    // Blank minutes digits keep the previous minutes value
    mark();
    digit(0, 9, 8); digit(1, 5, 8); digit(2, 15, 8); digit(3, 15, 8); idle();
    check("t3_fv", 32'(fv_cnt - fv0), 1);
    check("t3_blank", 32'(blank), 32'b1100);
    check("t3_digits", 32'(digits), 32'hFF59);
    check("t3_min", 32'(minutes), 24);
    check("t3_sec", 32'(seconds), 59);

    // Illegal segment pattern, multi-hot select, undriven select
    mark();
    digit(0, 4, 8); dwell(4'b1101, 8'hD5, 8);
    check("t4_illegal_err", 32'(err_cnt - err0), 1);
    digit(2, 3, 8); digit(3, 1, 8); idle();
    check("t4_incomplete", 32'(fv_cnt - fv0), 0);
    digit(1, 2, 8); idle();
    check("t4_fv", 32'(fv_cnt - fv0), 1);
    check("t4_digits", 32'(digits), 32'h1324);
    check("t4_min", 32'(minutes), 13);
    check("t4_sec", 32'(seconds), 24);
    mark();
    dwell(4'b1100, seg(0), 8); idle();
    check("t4_multihot_err", 32'(err_cnt - err0), 1);
    mark();
    dwell(4'hF, seg(8), 8); idle();
    check("t4_nosel_err", 32'(err_cnt - err0), 0);

    // Seconds overflow: err coincides with frame_valid, seconds holds
    mark();
    digit(0, 0, 8); digit(1, 6, 8); digit(2, 0, 8); digit(3, 0, 8); idle();
    check("t5_fv", 32'(fv_cnt - fv0), 1);
    check("t5_err", 32'(err_cnt - err0), 1);
    check("t5_both", 32'(both_cnt - both0), 1);
    check("t5_digits", 32'(digits), 32'h0060);
    check("t5_min", 32'(minutes), 0);
    check("t5_sec", 32'(seconds), 24);

    // Reset mid-frame discards partial capture
    mark();
    digit(0, 7, 8); digit(1, 8, 8);
    select = 4'hF; sevensegment = 8'hFF;
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    digit(2, 9, 8); digit(3, 1, 8); idle();
    check("t6_nofv", 32'(fv_cnt - fv0), 0);
    check("t6_digits_rst", 32'(digits), 32'hFFFF);
    check("t6_blank_rst", 32'(blank), 32'hF);
    check("t6_min_rst", 32'(minutes), 0);
    check("t6_sec_rst", 32'(seconds), 0);
    digit(0, 5, 8); digit(1, 4, 8); idle();
    check("t6_fv", 32'(fv_cnt - fv0), 1);
    check("t6_digits", 32'(digits), 32'h1945);
    check("t6_min", 32'(minutes), 19);
    check("t6_sec", 32'(seconds), 45);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver.
- Watches the 4-digit anode-select and segment buses and decodes each digit's segment pattern back to BCD.
- Reassembles complete frames into minutes/seconds values.
- Used for on-board loopback self-check and as the bench monitor for the display path.

Parameters:
- SETTLE, 4, consecutive cycles a select/segment combination must stay unchanged before it is captured (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- select  input  4  anode select, active-low; bit 3 = minutes tens, bit 0 = seconds units
- sevensegment  input  8  segment bus, active-low; bit0=a … bit6=g, bit7=dp (dp ignored)
- digits  output  16  captured BCD digits, [15:12]=d3 … [3:0]=d0; 4'hF for blank
- blank  output  4  per-digit blank flag from the last completed frame
- minutes  output  7  binary d3*10+d2
- seconds  output  6  binary d1*10+d0
- frame_valid  output  1  one-cycle pulse when a complete frame has been assembled
- err  output  1  one-cycle pulse on an illegal pattern, multi-hot select, or seconds > 59

Behaviour:
- Input stage: select and sevensegment are registered once (s_sel, s_seg). All decisions use the registered values.
- Stability counter (stab_cnt):
  - Cleared to 0 whenever {s_sel, s_seg[6:0]} differs from the previous cycle; otherwise increments, saturating at SETTLE.
  - Capture strobe fires on the single cycle stab_cnt transitions SETTLE-1 → SETTLE, i.e. once per dwell.
  - A dwell shorter than SETTLE cycles is never captured.
- Select classification at the capture strobe:
  - s_sel == 4'hF: no digit is driven; ignored, no err.
  - Exactly one bit low: index k = position of that bit.
  - Two or more bits low: err pulses; nothing captured.
- Segment decode, s_seg[6:0] in active-low hex:
  - 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9, 7F=blank.
  - Any other pattern: err pulses; digit k is not captured.
- Capture: the decoded value is written into a staging register slot k, and mask bit k is set. Recapturing the same k before the frame completes overwrites the slot.
- Frame completion:
  - On the cycle mask becomes 4'hF (including when the 4th capture arrives), the next edge does the following:
    - Copy the staging registers to digits and blank.
    - Pulse frame_valid for 1 cycle.
    - Clear mask.
  - Minutes update only if neither d3 nor d2 is blank; otherwise minutes holds its previous value. Seconds follow the same rule with d1/d0. This covers adjust-mode blinking.
  - If the new seconds value would exceed 59, err pulses with frame_valid, and seconds holds its previous value.
- Latency: segment change → capture strobe = 1 (input reg) + SETTLE cycles. Last digit captured → frame_valid = 1 cycle.
- Simultaneous events: an err from a dwell and a frame completion may coincide; both pulses assert in the same cycle.
- Reset (synchronous, takes priority over everything):
  - digits = 16'hFFFF, blank = 4'hF, minutes = 0, seconds = 0, frame_valid = 0, err = 0.
  - mask = 0, stab_cnt = 0, staging registers = 4'hF.
  - Reset mid-frame discards the partial frame.
- Arithmetic: the multiply-by-10 is shift/add on 4-bit BCD values. minutes max 99 fits in 7 bits; seconds ≤ 59 fits in 6 bits.

Test Plan:
1. Normal scan: drive digits 1,2,3,4 (d3..d0; segments 79,24,30,19), each for 8 cycles with SETTLE=4, scanning d0→d3 → frame_valid one pulse after d3 capture; digits=16'h1234, minutes=12, seconds=34, err=0.
2. Glitch rejection: select=4'b1110 with segments 40 for 3 cycles, then change → no capture, mask unchanged. Same pattern held for 4 cycles → captured exactly once even if held 100 cycles.
3. Blank minutes: frame d3/d2 = 7F and d1/d0 = 5,9 after a prior frame of 12:34 → blank=4'b1100, digits=16'hFF59, minutes stays 12, seconds=59.
4. Illegal inputs: segments 7'h55 on d1 → err 1-cycle pulse, frame not completed until a legal d1 arrives. select=4'b1100 held SETTLE cycles → err pulse. select=4'hF → no err.
5. Seconds overflow: frame 0,0,6,0 → frame_valid and err in the same cycle; digits=16'h0060, minutes=0, seconds keeps its prior value.
6. Reset mid-frame: capture d0,d1, assert reset 1 cycle, then capture d2,d3 only → no frame_valid. All outputs hold reset values until all four digits are captured again.
